// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: row drive, column sync, debounce FSM, 4-deep FWFT key FIFO.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DWELLS = 200
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rows,
  input  logic [3:0] columns,
  output logic [3:0] key_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  input  logic       clr_ovf,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {SCAN = 2'd0, CONFIRM = 2'd1, PUSH = 2'd2, RELEASE = 2'd3} state_t;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [4:0]       cnt_inc;
  logic             sample, onehot, match, reach;
  logic [1:0]       col_idx, row_idx;
  logic [3:0]       row_next;
  logic             push_norm, push_req;
  logic [3:0]       push_code;

  logic [3:0] mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] count_q;
  logic       ovf_q;
  logic       full, pop, do_push, drop;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign sample   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign div_d    = sample ? '0 : div_q + 1'b1;
  assign onehot   = (sync2_q != 4'd0) && ((sync2_q & (sync2_q - 4'd1)) == 4'd0);
  assign col_idx  = {sync2_q[3] | sync2_q[2], sync2_q[3] | sync2_q[1]};
  assign row_idx  = {row_q[3] | row_q[2], row_q[3] | row_q[1]};
  assign match    = onehot && (col_idx == col_q);
  assign row_next = {row_q[2:0], row_q[3]};
  assign cnt_inc  = {1'b0, cnt_q} + 5'd1;
  assign reach    = (cnt_inc >= 5'(DEBOUNCE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SCAN;
      div_q   <= '0;
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      row_q   <= 4'b0001;
      col_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sync1_q <= columns;
      sync2_q <= sync1_q;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    push_norm = 1'b0;
    case (state_q)
      SCAN: if (sample) begin
        if (onehot) begin
          state_d = CONFIRM;
          col_d   = col_idx;
          cnt_d   = 4'd1;
        end else begin
          row_d = row_next;
        end
      end
      CONFIRM: if (sample) begin
        if (match && reach) begin
          state_d = PUSH;
          cnt_d   = 4'd0;
        end else if (match) begin
          cnt_d = cnt_inc[3:0];
        end else begin
          state_d = SCAN;
          row_d   = row_next;
          cnt_d   = 4'd0;
        end
      end
      PUSH: begin
        push_norm = 1'b1;
        state_d   = RELEASE;
        cnt_d     = 4'd0;
      end
      default: if (sample) begin
        // cnt_q counts consecutive "no key" samples here
        if (onehot) begin
          cnt_d = 4'd0;
        end else if (reach) begin
          state_d = SCAN;
          row_d   = row_next;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_inc[3:0];
        end
      end
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DWELLS + 1);
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W:0]   rep_inc;
  logic             rep_push;

  assign rep_inc = {1'b0, rep_q} + 1'b1;

  always_comb begin
    rep_d    = rep_q;
    rep_push = 1'b0;
    if (state_q != RELEASE) begin
      rep_d = '0;
    end else if (sample) begin
      if (match && (rep_inc == (REP_W+1)'(REPEAT_DWELLS))) begin
        rep_push = 1'b1;
        rep_d    = '0;
      end else if (match) begin
        rep_d = rep_inc[REP_W-1:0];
      end else begin
        rep_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= '0;
    else      rep_q <= rep_d;
  end

  assign push_req = push_norm | rep_push;
`else
  if (REPEAT_DWELLS < 1) begin : g_repeat_unused
  end
  assign push_req = push_norm;
`endif

  assign push_code = key_code(row_idx, col_q);

  // Consumer handshake: key_data is held stable while key_valid=1; an entry is
  // removed on any cycle where key_valid and key_ready are both 1.
  assign full    = (count_q == 3'd4);
  assign pop     = key_valid & key_ready;
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 4'd0;
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_code;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign rows      = row_q;
  assign key_valid = (count_q != 3'd0);
  assign key_data  = key_valid ? mem_q[rd_q] : 4'd0;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model drives columns from rows,
// with a raw override for glitch and multi-hot patterns.
module tb_keypad_scan_ctrl;

  localparam logic [1:0] S_SCAN = 2'd0, S_CONFIRM = 2'd1, S_PUSH = 2'd2, S_RELEASE = 2'd3;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_REP = 4;
`else
  localparam int EXP_REP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] columns;
  logic [3:0] key_data;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
  logic       clr_ovf;
  logic [1:0] dbg_state;

  logic       key_down, raw_mode;
  logic [1:0] kr, kc;
  logic [3:0] raw_cols;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign columns = raw_mode ? raw_cols :
                   ((key_down && rows[kr]) ? (4'b0001 << kc) : 4'b0000);

  keypad_scan_ctrl #(.SCAN_DIV(8), .DEBOUNCE(2), .REPEAT_DWELLS(3)) dut (
    .clk(clk), .rst(rst), .rows(rows), .columns(columns),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .overflow(overflow), .clr_ovf(clr_ovf), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_row_entry(input logic [3:0] r, output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev = rows;
      @(posedge clk); #1;
      if (rows == r && prev != r) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input string tag);
    bit ok;
    kr = r; kc = c; key_down = 1'b1;
    wait_state(S_RELEASE, 120, ok);
    chk({tag, "_push"}, {3'b000, ok}, 4'd1);
    key_down = 1'b0;
    wait_state(S_SCAN, 80, ok);
    chk({tag, "_rel"}, {3'b000, ok}, 4'd1);
  endtask

  task automatic pop_chk(input logic [3:0] exp, input string tag);
    chk({tag, "_valid"}, {3'b000, key_valid}, 4'd1);
    chk({tag, "_data"}, key_data, exp);
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
  endtask

  task automatic reset_and_dwell_check(input string tag);
    @(negedge clk) rst = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk({tag, "_row0_hold"}, rows, 4'b0001);
    @(posedge clk);
    #1 chk({tag, "_row1"}, rows, 4'b0010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    rst = 1'b0; key_ready = 1'b0; clr_ovf = 1'b0;
    key_down = 1'b0; raw_mode = 1'b0; raw_cols = 4'd0; kr = 2'd0; kc = 2'd0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rows", rows, 4'b0001);
    chk("rst_state", {2'b00, dbg_state}, {2'b00, S_SCAN});
    chk("rst_valid", {3'b000, key_valid}, 4'd0);
    chk("rst_data", key_data, 4'd0);
    chk("rst_ovf", {3'b000, overflow}, 4'd0);
    reset_and_dwell_check("dwell");

    // key 8 (row 2, col 1): one event
    press(2'd2, 2'd1, "k8");
    chk("k8_ovf", {3'b000, overflow}, 4'd0);
    pop_chk(4'h8, "k8_pop");
    chk("k8_single", {3'b000, key_valid}, 4'd0);
    chk("k8_empty_data", key_data, 4'd0);

    // one-dwell glitch on row 0: no event, scan moves on
    wait_row_entry(4'b0001, ok);
    chk("glitch_sync", {3'b000, ok}, 4'd1);
    raw_mode = 1'b1; raw_cols = 4'b0001;
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_confirm", {2'b00, dbg_state}, {2'b00, S_CONFIRM});
    chk("glitch_row_held", rows, 4'b0001);
    raw_cols = 4'b0000;
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_row_next", rows, 4'b0010);
    chk("glitch_state", {2'b00, dbg_state}, {2'b00, S_SCAN});
    chk("glitch_no_event", {3'b000, key_valid}, 4'd0);

    // multi-hot column on row 1: treated as no key
    wait_row_entry(4'b0010, ok);
    chk("multi_sync", {3'b000, ok}, 4'd1);
    raw_cols = 4'b0011;
    repeat (8) @(posedge clk);
    #1;
    chk("multi_row2", rows, 4'b0100);
    chk("multi_state", {2'b00, dbg_state}, {2'b00, S_SCAN});
    repeat (8) @(posedge clk);
    #1;
    chk("multi_row3", rows, 4'b1000);
    chk("multi_no_event", {3'b000, key_valid}, 4'd0);
    raw_mode = 1'b0; raw_cols = 4'b0000;

    // five presses without consumer: fourth fills, fifth overflows
    press(2'd0, 2'd0, "f1");
    press(2'd1, 2'd1, "f5");
    press(2'd2, 2'd2, "f9");
    press(2'd3, 2'd0, "fE");
    chk("full_no_ovf", {3'b000, overflow}, 4'd0);
    press(2'd0, 2'd3, "fA");
    chk("full_ovf", {3'b000, overflow}, 4'd1);
    chk("full_head", key_data, 4'h1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("clr_ovf", {3'b000, overflow}, 4'd0);
    pop_chk(4'h1, "fifo0");
    pop_chk(4'h5, "fifo1");
    pop_chk(4'h9, "fifo2");
    pop_chk(4'hE, "fifo3");
    chk("fifo_drained", {3'b000, key_valid}, 4'd0);

    // push and pop in the same cycle while full
    press(2'd0, 2'd1, "g2");
    press(2'd1, 2'd0, "g4");
    press(2'd1, 2'd2, "g6");
    press(2'd2, 2'd0, "g7");
    kr = 2'd3; kc = 2'd3; key_down = 1'b1;
    wait_state(S_PUSH, 120, ok);
    chk("kD_push_seen", {3'b000, ok}, 4'd1);
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
    chk("kD_no_ovf", {3'b000, overflow}, 4'd0);
    chk("kD_head", key_data, 4'h4);
    key_down = 1'b0;
    wait_state(S_SCAN, 80, ok);
    chk("kD_rel", {3'b000, ok}, 4'd1);
    pop_chk(4'h4, "gfifo0");
    pop_chk(4'h6, "gfifo1");
    pop_chk(4'h7, "gfifo2");
    pop_chk(4'hD, "gfifo3");
    chk("gfifo_drained", {3'b000, key_valid}, 4'd0);

    // reset asserted mid-CONFIRM with one entry queued
    press(2'd0, 2'd2, "k3");
    kr = 2'd3; kc = 2'd1; key_down = 1'b1;
    wait_state(S_CONFIRM, 120, ok);
    chk("mid_confirm_seen", {3'b000, ok}, 4'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_rows", rows, 4'b0001);
    chk("mid_rst_state", {2'b00, dbg_state}, {2'b00, S_SCAN});
    chk("mid_rst_valid", {3'b000, key_valid}, 4'd0);
    chk("mid_rst_data", key_data, 4'd0);
    chk("mid_rst_ovf", {3'b000, overflow}, 4'd0);
    key_down = 1'b0;
    repeat (2) @(posedge clk);
    reset_and_dwell_check("mid_restart");
    repeat (40) @(posedge clk);
    #1 chk("mid_press_discarded", {3'b000, key_valid}, 4'd0);

    // key 5 held ten dwells past the push
    kr = 2'd1; kc = 2'd1; key_down = 1'b1;
    wait_state(S_RELEASE, 120, ok);
    chk("hold_push", {3'b000, ok}, 4'd1);
    repeat (80) @(posedge clk);
    #1 key_down = 1'b0;
    wait_state(S_SCAN, 80, ok);
    chk("hold_rel", {3'b000, ok}, 4'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (key_valid) begin
        n++;
        pop_chk(4'h5, "hold_code");
      end
    end
    chk("hold_events", 4'(n), 4'(EXP_REP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each row is driven (dwell); legal >= 4.
REQ-002 Parameter DEBOUNCE, default 4: consecutive matching dwell samples needed to accept a press or a release; legal 1..15.
REQ-003 Parameter REPEAT_DWELLS, default 200: dwell periods between auto-repeat events; used only under KEYPAD_REPEAT_EN.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 rows  out  4  one-hot row drive; bit n drives row n.
REQ-007 columns  in  4  raw column sense, asynchronous; bit n = column n.
REQ-008 key_data  out  4  key code at FIFO head.
REQ-009 key_valid  out  1  FIFO non-empty.
REQ-010 key_ready  in  1  consumer accepts head; pop on a cycle where key_valid and key_ready are both 1.
REQ-011 overflow  out  1  sticky, set when a key event is dropped.
REQ-012 clr_ovf  in  1  synchronous one-cycle clear of overflow.

Function
REQ-013 columns SHALL pass a 2-flop synchronizer; only synchronized values are used.
REQ-014 Sample point SHALL be the last cycle of each dwell; exactly one sample per dwell.
REQ-015 Valid sample SHALL have exactly one column bit set; zero or multi-hot SHALL count as "no key".
REQ-016 Key map (row,col->code): r0 1,2,3,A; r1 4,5,6,B; r2 7,8,9,C; r3 E,0,F,D.
REQ-017 FSM states: SCAN, CONFIRM, PUSH, RELEASE.
REQ-018 SCAN: rows advances 0001->0010->0100->1000->0001 after each dwell; a valid sample SHALL go to CONFIRM, holding the current row, and latch the column (debounce count = 1).
REQ-019 CONFIRM: row held; each sample equal to the latched column increments the count; count reaching DEBOUNCE -> PUSH; any other sample -> SCAN at the next row, no event.
REQ-020 PUSH: lasts exactly one cycle; writes the mapped code to the FIFO; then -> RELEASE.
REQ-021 RELEASE: row held; DEBOUNCE consecutive "no key" samples -> SCAN at the next row; any key sample resets the release count.
REQ-022 Reaching PUSH with DEBOUNCE=1 SHALL take exactly one dwell after the first valid sample; key_valid SHALL rise the cycle after PUSH when the FIFO was empty.
REQ-023 FIFO depth 4, first-word-fall-through; key_data SHALL be 0 when empty.
REQ-024 Push when full without a same-cycle pop SHALL drop the code and set overflow; FIFO contents are unchanged.
REQ-025 Push and pop in the same cycle when full SHALL both succeed with no overflow; when empty, only the push takes effect.
REQ-026 clr_ovf and a new drop in the same cycle: set SHALL win.
REQ-027 Pointers SHALL wrap modulo 4; occupancy is held in a 3-bit count.

Reset
REQ-028 rst low SHALL immediately force: rows=0001, state SCAN, all counters and synchronizer flops 0, FIFO empty, key_valid=0, key_data=0, overflow=0.
REQ-029 Reset asserted mid-press SHALL discard the press; after release, scanning restarts at row 0 with a full dwell.

Configuration
REQ-030 Macro KEYPAD_REPEAT_EN defined: in RELEASE, every REPEAT_DWELLS consecutive key samples equal to the latched column SHALL trigger one extra push of the same code, with overflow rules as for normal pushes.
REQ-031 Macro absent: exactly one event per debounced press; the repeat counter SHALL not be synthesized.

Verification
REQ-032 SCAN_DIV=8, DEBOUNCE=2, hold column 0010 while rows=0100 for 3 dwells -> exactly one event, key_data=8, key_valid=1.
REQ-033 Column 0001 asserted during 1 dwell of row 0, DEBOUNCE=2 -> no event; rows continues to 0010.
REQ-034 Columns 0011 held on row 1 -> no event; scan continues.
REQ-035 5 distinct presses, key_ready=0 -> 4 entries retained in order, overflow=1; clr_ovf pulse -> overflow=0; 4 pops return the first 4 codes.
REQ-036 Press of key D (row 3, col 3) with key_ready=1 and push/pop at full -> no overflow; rst pulsed low mid-CONFIRM -> all outputs at reset values.
REQ-037 KEYPAD_REPEAT_EN, REPEAT_DWELLS=3, key 5 held 10 dwells past PUSH -> 1+3 events of code 5; without the macro -> 1 event.
